// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port byte-enable RAM family.
//   RDW_OLD / RDW_NEW : same-port read-during-write selectors
//   calc_num_bytes    : byte-lane count for a word/lane width pair
//   byte_merge        : lane-wise merge of a new word into an old word
// byte_merge works on a fixed wide container so that any instance width up to
// MERGE_W bits can share it; callers widen on the way in and truncate on the way out.
package ram_pkg;

  localparam int unsigned RDW_OLD  = 0;
  localparam int unsigned RDW_NEW  = 1;

  localparam int unsigned MERGE_W  = 256;
  localparam int unsigned MERGE_IW = $clog2(MERGE_W);

  typedef logic [MERGE_W-1:0] merge_word_t;
  typedef logic [MERGE_W-1:0] merge_be_t;

  function automatic int unsigned calc_num_bytes(input int unsigned dw, input int unsigned bw);
    return (bw == 0) ? 0 : dw / bw;
  endfunction

  // Bit j belongs to lane j/bw; it takes the new value when that lane is enabled.
  function automatic merge_word_t byte_merge(input merge_word_t old_w,
                                             input merge_word_t new_w,
                                             input merge_be_t   be,
                                             input int unsigned bw);
    merge_word_t r;
    r = old_w;
    for (int unsigned j = 0; j < MERGE_W; j++) begin
      if (bw != 0 && be[MERGE_IW'(j / bw)]) begin
        r[MERGE_IW'(j)] = new_w[MERGE_IW'(j)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// Per-port read-data / valid pipeline for the dual-port RAM.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   i_en         : an access is accepted on this edge
//   i_data       : read word belonging to the accepted access
//   o_data       : read data, holds its last value while o_valid is low
//   o_valid      : o_data carries a fresh read result this cycle
// Latency is one edge, or two with OUT_REG != 0.
module ram_port_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // Data only loads on an access so idle cycles hold the previous result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= i_en;
      if (i_en) begin
        r_s1_data <= i_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign o_data  = r_s2_data;
      assign o_valid = r_s2_valid;
    end else begin : g_noreg
      assign o_data  = r_s1_data;
      assign o_valid = r_s1_valid;
    end
  endgenerate

endmodule

// File: rtl/ram_dp_sr_sw_be.sv
// True dual-port synchronous RAM with per-byte write enables.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   a_en / b_en           : access enable (every access is a read)
//   a_we / b_we           : access also writes the enabled byte lanes
//   a_be / b_be           : byte-lane write enables
//   a_addr / b_addr       : word address
//   a_di / b_di           : write data
//   a_do / b_do           : read data (held while valid is low)
//   a_valid / b_valid     : read data valid, 1 + OUT_REG edges after the access
// Same-port read-during-write follows RDW_MODE; cross-port reads see old data;
// on a same-address double write, port A owns every lane it enables.
module ram_dp_sr_sw_be
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned NUM_BYTES  = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH),
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned RDW_MODE   = RDW_OLD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NUM_BYTES-1:0]  a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_di,
  output logic [DATA_WIDTH-1:0] a_do,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [NUM_BYTES-1:0]  b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_di,
  output logic [DATA_WIDTH-1:0] b_do,
  output logic                  b_valid
);

  localparam int unsigned IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_a_acc,   w_b_acc;
  logic                  w_a_inr,   w_b_inr;
  logic [IDX_W-1:0]      w_a_idx,   w_b_idx;
  logic [DATA_WIDTH-1:0] w_a_old,   w_b_old;
  logic [NUM_BYTES-1:0]  w_a_be_wr, w_b_be_wr;
  logic                  w_a_wr,    w_b_wr;
  logic [DATA_WIDTH-1:0] w_a_own,   w_b_own;
  logic [DATA_WIDTH-1:0] w_a_rd,    w_b_rd;
  logic                  w_same;
  logic [DATA_WIDTH-1:0] w_a_final;

  always_comb begin
    w_a_acc   = a_en & ~reset;
    w_b_acc   = b_en & ~reset;
    w_a_inr   = (32'(a_addr) < RAM_DEPTH);
    w_b_inr   = (32'(b_addr) < RAM_DEPTH);
    w_a_idx   = IDX_W'(a_addr);
    w_b_idx   = IDX_W'(b_addr);

    // Out-of-range accesses read as zero and never write.
    w_a_old   = w_a_inr ? r_mem[w_a_idx] : '0;
    w_b_old   = w_b_inr ? r_mem[w_b_idx] : '0;
    w_a_be_wr = (w_a_acc && a_we && w_a_inr) ? a_be : '0;
    w_b_be_wr = (w_b_acc && b_we && w_b_inr) ? b_be : '0;
    w_a_wr    = |w_a_be_wr;
    w_b_wr    = |w_b_be_wr;

    w_a_own   = DATA_WIDTH'(byte_merge(merge_word_t'(w_a_old), merge_word_t'(a_di),
                                       merge_be_t'(w_a_be_wr), BYTE_WIDTH));
    w_b_own   = DATA_WIDTH'(byte_merge(merge_word_t'(w_b_old), merge_word_t'(b_di),
                                       merge_be_t'(w_b_be_wr), BYTE_WIDTH));

    // Double write to one word: layer A's lanes over B's merge and commit
    // through port A only, so the array sees a single write for that word.
    w_same    = w_a_wr & w_b_wr & (a_addr == b_addr);
    w_a_final = w_same ? DATA_WIDTH'(byte_merge(merge_word_t'(w_b_own), merge_word_t'(a_di),
                                                merge_be_t'(w_a_be_wr), BYTE_WIDTH))
                       : w_a_own;

    // Write-first returns only this port's own merge; the other port is never visible.
    w_a_rd    = (RDW_MODE == RDW_NEW) ? w_a_own : w_a_old;
    w_b_rd    = (RDW_MODE == RDW_NEW) ? w_b_own : w_b_old;
  end

  always_ff @(posedge clock) begin
    if (w_b_wr && !w_same) begin
      r_mem[w_b_idx] <= w_b_own;
    end
    if (w_a_wr) begin
      r_mem[w_a_idx] <= w_a_final;
    end
  end

  ram_port_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_a (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_a_acc),
    .i_data  (w_a_rd),
    .o_data  (a_do),
    .o_valid (a_valid)
  );

  ram_port_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_b (
    .clock   (clock),
    .reset   (reset),
    .i_en    (w_b_acc),
    .i_data  (w_b_rd),
    .o_data  (b_do),
    .o_valid (b_valid)
  );

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// Scoreboard bench: two RAM instances share one stimulus stream.
//   dut0: full depth, OUT_REG=0, read-first
//   dut1: depth 200, OUT_REG=1, write-first
// Channels: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
module tb_ram_dp_sr_sw_be;

  localparam int unsigned DW     = 16;
  localparam int unsigned BW     = 8;
  localparam int unsigned AW     = 8;
  localparam int unsigned NB     = 2;
  localparam int unsigned DEPTH1 = 200;

  typedef struct {
    bit            en;
    bit            we;
    logic [NB-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } port_t;

  typedef struct {
    int unsigned   ch;
    int unsigned   due;
    logic [DW-1:0] data;
    bit            chk;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_en, a_we, b_en, b_we;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_di, b_di;
  logic [DW-1:0] a_do0, b_do0, a_do1, b_do1;
  logic          a_v0, b_v0, a_v1, b_v1;

  always #5 clk = ~clk;

  ram_dp_sr_sw_be #(
    .DATA_WIDTH (DW), .BYTE_WIDTH (BW), .ADDR_WIDTH (AW),
    .OUT_REG    (0),  .RDW_MODE   (0)
  ) dut0 (
    .clock (clk), .reset (reset),
    .a_en (a_en), .a_we (a_we), .a_be (a_be), .a_addr (a_addr), .a_di (a_di),
    .a_do (a_do0), .a_valid (a_v0),
    .b_en (b_en), .b_we (b_we), .b_be (b_be), .b_addr (b_addr), .b_di (b_di),
    .b_do (b_do0), .b_valid (b_v0)
  );

  ram_dp_sr_sw_be #(
    .DATA_WIDTH (DW), .BYTE_WIDTH (BW), .ADDR_WIDTH (AW), .RAM_DEPTH (DEPTH1),
    .OUT_REG    (1),  .RDW_MODE   (1)
  ) dut1 (
    .clock (clk), .reset (reset),
    .a_en (a_en), .a_we (a_we), .a_be (a_be), .a_addr (a_addr), .a_di (a_di),
    .a_do (a_do1), .a_valid (a_v1),
    .b_en (b_en), .b_we (b_we), .b_be (b_be), .b_addr (b_addr), .b_di (b_di),
    .b_do (b_do1), .b_valid (b_v1)
  );

  // Reference model state
  logic [DW-1:0] m [2][256];
  exp_t          sb[$];
  int unsigned   cyc = 0;
  logic          rst_edge = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  function automatic logic [DW-1:0] merge_w(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int l = 0; l < NB; l++)
      if (be[l]) r[l*BW +: BW] = n[l*BW +: BW];
    return r;
  endfunction

  function automatic port_t p_idle();
    port_t p;
    p = '{en: 1'b0, we: 1'b0, be: '0, addr: '0, di: '0};
    return p;
  endfunction

  function automatic port_t p_rd(input logic [AW-1:0] addr);
    port_t p;
    p = '{en: 1'b1, we: 1'b0, be: '0, addr: addr, di: '0};
    return p;
  endfunction

  function automatic port_t p_wr(input logic [AW-1:0] addr, input logic [DW-1:0] di,
                                 input logic [NB-1:0] be);
    port_t p;
    p = '{en: 1'b1, we: 1'b1, be: be, addr: addr, di: di};
    return p;
  endfunction

  // One clock: drive both ports, predict the reads from pre-edge contents, then
  // apply writes (B first, then A, so A owns shared lanes).
  task automatic step(input bit rst, input port_t pa, input port_t pb, input bit cd);
    int unsigned   depth;
    int unsigned   lat;
    logic [DW-1:0] old;
    logic [DW-1:0] rd;
    @(posedge clk);
    #1;
    reset  = rst;
    a_en   = pa.en;  a_we = pa.we;  a_be = pa.be;  a_addr = pa.addr;  a_di = pa.di;
    b_en   = pb.en;  b_we = pb.we;  b_be = pb.be;  b_addr = pb.addr;  b_di = pb.di;
    if (rst) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due > cyc) sb.delete(i);
    end else begin
      for (int d = 0; d < 2; d++) begin
        depth = (d == 0) ? 256 : DEPTH1;
        lat   = (d == 0) ? 1 : 2;
        if (pa.en) begin
          old = (int'(pa.addr) < int'(depth)) ? m[d][pa.addr] : '0;
          rd  = (d == 1 && pa.we && int'(pa.addr) < int'(depth)) ? merge_w(old, pa.di, pa.be) : old;
          sb.push_back('{ch: d*2, due: cyc + lat, data: rd, chk: cd});
        end
        if (pb.en) begin
          old = (int'(pb.addr) < int'(depth)) ? m[d][pb.addr] : '0;
          rd  = (d == 1 && pb.we && int'(pb.addr) < int'(depth)) ? merge_w(old, pb.di, pb.be) : old;
          sb.push_back('{ch: d*2 + 1, due: cyc + lat, data: rd, chk: cd});
        end
        if (pb.en && pb.we && int'(pb.addr) < int'(depth))
          m[d][pb.addr] = merge_w(m[d][pb.addr], pb.di, pb.be);
        if (pa.en && pa.we && int'(pa.addr) < int'(depth))
          m[d][pa.addr] = merge_w(m[d][pa.addr], pa.di, pa.be);
      end
    end
  endtask

  // Monitor: every negedge, each channel either delivers its due result,
  // or stays invalid with its data held.
  logic [DW-1:0] last [4];
  bit            last_ok [4];

  always @(negedge clk) begin
    logic          v;
    logic [DW-1:0] d;
    int            idx;
    for (int ch = 0; ch < 4; ch++) begin
      case (ch)
        0:       begin v = a_v0; d = a_do0; end
        1:       begin v = b_v0; d = b_do0; end
        2:       begin v = a_v1; d = a_do1; end
        default: begin v = b_v1; d = b_do1; end
      endcase
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].ch == ch) idx = i;
      checks++;
      if (rst_edge) begin
        if (v !== 1'b0 || d !== '0) begin
          errors++;
          $display("FAIL reset ch%0d cyc%0d: got v=%0b d=%h, want v=0 d=0000", ch, cyc, v, d);
        end
        last[ch]    = '0;
        last_ok[ch] = 1'b1;
      end else if (idx >= 0 && sb[idx].due <= cyc) begin
        if (sb[idx].chk) begin
          if (v !== 1'b1 || d !== sb[idx].data || sb[idx].due != cyc) begin
            errors++;
            $display("FAIL read ch%0d cyc%0d: got v=%0b d=%h, want v=1 d=%h due%0d",
                     ch, cyc, v, d, sb[idx].data, sb[idx].due);
          end
          last[ch]    = sb[idx].data;
          last_ok[ch] = 1'b1;
        end else begin
          if (v !== 1'b1) begin
            errors++;
            $display("FAIL latency ch%0d cyc%0d: got v=%0b, want v=1", ch, cyc, v);
          end
          last_ok[ch] = 1'b0;
        end
        sb.delete(idx);
      end else begin
        if (v !== 1'b0) begin
          errors++;
          $display("FAIL spurious ch%0d cyc%0d: got v=%0b, want v=0", ch, cyc, v);
        end else if (last_ok[ch] && d !== last[ch]) begin
          errors++;
          $display("FAIL hold ch%0d cyc%0d: got d=%h, want d=%h", ch, cyc, d, last[ch]);
        end
      end
    end
  end

  initial begin
    port_t pa, pb;
    for (int ch = 0; ch < 4; ch++) begin
      last[ch]    = '0;
      last_ok[ch] = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) m[d][i] = '0;
    reset = 1'b1;
    a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_di = '0;
    b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_di = '0;

    repeat (3) step(1, p_idle(), p_idle(), 1);

    // Fill every word; the reads riding on these writes see unwritten data.
    for (int i = 0; i < 128; i++)
      step(0, p_wr(AW'(i), DW'($urandom), 2'b11), p_wr(AW'(i + 128), DW'($urandom), 2'b11), 0);
    step(0, p_idle(), p_idle(), 1);

    // Plain write then read
    step(0, p_wr(8'h10, 16'hBEEF, 2'b11), p_idle(), 1);
    step(0, p_rd(8'h10), p_idle(), 1);
    // Byte enables
    step(0, p_idle(), p_wr(8'h20, 16'h1234, 2'b11), 1);
    step(0, p_idle(), p_wr(8'h20, 16'hABCD, 2'b01), 1);
    step(0, p_idle(), p_rd(8'h20), 1);
    // Same-port read-during-write
    step(0, p_wr(8'h30, 16'h1111, 2'b11), p_idle(), 1);
    step(0, p_wr(8'h30, 16'h2222, 2'b11), p_idle(), 1);
    step(0, p_rd(8'h30), p_idle(), 1);
    // Same-address double writes
    step(0, p_wr(8'h40, 16'hAAAA, 2'b11), p_wr(8'h40, 16'h5555, 2'b10), 1);
    step(0, p_rd(8'h40), p_idle(), 1);
    step(0, p_wr(8'h40, 16'h0000, 2'b11), p_idle(), 1);
    step(0, p_wr(8'h40, 16'hAAAA, 2'b01), p_wr(8'h40, 16'h5555, 2'b10), 1);
    step(0, p_rd(8'h40), p_idle(), 1);
    // Cross-port read during write
    step(0, p_idle(), p_wr(8'h50, 16'h0F0F, 2'b11), 1);
    step(0, p_wr(8'h50, 16'h7777, 2'b11), p_rd(8'h50), 1);
    step(0, p_idle(), p_rd(8'h50), 1);
    // Pure read via we=1 with no lanes
    step(0, p_wr(8'h50, 16'hFFFF, 2'b00), p_idle(), 1);
    // Out-of-range on dut1
    step(0, p_wr(8'hF0, 16'hC3C3, 2'b11), p_wr(8'hC8, 16'h3C3C, 2'b11), 1);
    step(0, p_rd(8'hF0), p_rd(8'hC8), 1);
    // Reset while reads are in flight
    step(0, p_rd(8'h10), p_rd(8'h20), 1);
    step(0, p_rd(8'h30), p_rd(8'h40), 1);
    step(1, p_wr(8'h10, 16'hDEAD, 2'b11), p_rd(8'h50), 1);
    step(0, p_idle(), p_idle(), 1);
    step(0, p_idle(), p_idle(), 1);
    step(0, p_rd(8'h10), p_rd(8'h20), 1);
    step(0, p_idle(), p_idle(), 1);

    // Randomised traffic, narrow address set half the time to force collisions
    for (int n = 0; n < 3000; n++) begin
      pa.en   = ($urandom_range(0, 9) < 7);
      pa.we   = $urandom_range(0, 1);
      pa.be   = NB'($urandom);
      pa.addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      pa.di   = DW'($urandom);
      pb.en   = ($urandom_range(0, 9) < 7);
      pb.we   = $urandom_range(0, 1);
      pb.be   = NB'($urandom);
      pb.addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      pb.di   = DW'($urandom);
      step(($urandom_range(0, 99) == 0), pa, pb, 1);
    end

    repeat (5) step(0, p_idle(), p_idle(), 1);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
